// File: rtl/hbridge_pkg.sv
// Shared types and decode helpers for the H-bridge dead-time controller.
// Gate patterns are packed {hs1, ls1, hs2, ls2, damp1, damp2, busy}.
package hbridge_pkg;

  localparam int DT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_DT_A,
    ST_PH_A,
    ST_DT_B,
    ST_PH_B,
    ST_DT_DAMP,
    ST_DAMP
  } state_e;

  typedef struct packed {
    logic hs1;
    logic ls1;
    logic hs2;
    logic ls2;
    logic damp1;
    logic damp2;
    logic busy;
  } drive_t;

  localparam drive_t DRV_OFF  = 7'b000_0000;
  localparam drive_t DRV_PH_A = 7'b100_1000;
  localparam drive_t DRV_PH_B = 7'b011_0000;
  localparam drive_t DRV_DAMP = 7'b000_0110;
  localparam drive_t DRV_BUSY = 7'b000_0001;

  function automatic drive_t decode(input state_e s);
    drive_t d;
    d = DRV_OFF;
    case (s)
      ST_PH_A:    d = DRV_PH_A;
      ST_PH_B:    d = DRV_PH_B;
      ST_DAMP:    d = DRV_DAMP;
      ST_DT_A,
      ST_DT_B,
      ST_DT_DAMP: d = DRV_BUSY;
      default:    d = DRV_OFF;
    endcase
    return d;
  endfunction

  // Dead-time state that guards entry into a given target.
  function automatic state_e dt_of(input state_e t);
    state_e s;
    s = ST_OFF;
    case (t)
      ST_PH_A: s = ST_DT_A;
      ST_PH_B: s = ST_DT_B;
      ST_DAMP: s = ST_DT_DAMP;
      default: s = ST_OFF;
    endcase
    return s;
  endfunction

  function automatic logic is_dt(input state_e s);
    return (s == ST_DT_A) || (s == ST_DT_B) || (s == ST_DT_DAMP);
  endfunction

  function automatic state_e target_of(input logic en, input logic damp, input logic drive);
    state_e t;
    if (!en)        t = ST_OFF;
    else if (damp)  t = ST_DAMP;
    else if (drive) t = ST_PH_A;
    else            t = ST_PH_B;
    return t;
  endfunction

endpackage

// File: rtl/dt_counter.sv
// Dead-time interval counter: load latches D = max(dead_time,1), done once
// D cycles have been spent in the interval; the count saturates at D.
module dt_counter
  import hbridge_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [DT_W-1:0] dead_time,
  output logic            done
);

  logic [DT_W-1:0] cnt_q, cnt_d;
  logic [DT_W-1:0] len_q, len_d;

  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    if (load) begin
      len_d = (dead_time == '0) ? DT_W'(1) : dead_time;
      cnt_d = DT_W'(1);
    end else if (cnt_q != len_q) begin
      cnt_d = cnt_q + DT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  assign done = (cnt_q == len_q);

endmodule

// File: rtl/hbridge_deadtime.sv
// H-bridge gate sequencer: inserts an all-off dead-time interval before every
// phase or damping entry; disabling the bridge drops all gates immediately.
module hbridge_deadtime
  import hbridge_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DT_W-1:0] dead_time,
  input  logic            drive_in,
  input  logic            damp_in,
  output logic            hs1,
  output logic            ls1,
  output logic            hs2,
  output logic            ls2,
  output logic            damp1,
  output logic            damp2,
  output logic            busy
);

  logic   en_q, drive_q, damp_q;
  state_e state_q, state_d;
  state_e target;
  logic   load;
  logic   dt_done;
  drive_t drv_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q    <= 1'b0;
      drive_q <= 1'b0;
      damp_q  <= 1'b0;
    end else begin
      en_q    <= en;
      drive_q <= drive_in;
      damp_q  <= damp_in;
    end
  end

  assign target = target_of(en_q, damp_q, drive_q);

  dt_counter #(.DT_W(DT_W)) u_dt_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .dead_time (dead_time),
    .done      (dt_done)
  );

  // A changed target mid-interval restarts the count, even when it points
  // back at the state we just left.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (target == ST_OFF) begin
      state_d = ST_OFF;
    end else if (is_dt(state_q)) begin
      if (dt_of(target) != state_q) begin
        state_d = dt_of(target);
        load    = 1'b1;
      end else if (dt_done) begin
        state_d = target;
      end
    end else if (target != state_q) begin
      state_d = dt_of(target);
      load    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_OFF;
      drv_q   <= DRV_OFF;
    end else begin
      state_q <= state_d;
      drv_q   <= decode(state_d);
    end
  end

  assign hs1   = drv_q.hs1;
  assign ls1   = drv_q.ls1;
  assign hs2   = drv_q.hs2;
  assign ls2   = drv_q.ls2;
  assign damp1 = drv_q.damp1;
  assign damp2 = drv_q.damp2;
  assign busy  = drv_q.busy;

endmodule
